// File: rtl/cnn_frame_loader.sv
// Ping-pong frame loader: assembles a raster-ordered pixel stream into one of two
// banks and presents each complete frame to the cnn consumer as an unpacked array.
module cnn_frame_loader #(
    parameter int input_size = 28,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [data_width-1:0] frame_data [input_size*input_size-1:0],
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  frame_error,
    output logic [15:0]           frame_count
);
    localparam int N = input_size * input_size;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {FILL, DROP} wstate_t;

    logic [data_width-1:0] bank_q [2][N];

    wstate_t          wstate_q, wstate_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             error_q, error_d;
    logic [15:0]      count_q, count_d;
    logic             beat;
    logic             wr_en;

    always_comb begin
        wstate_d = wstate_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        wr_idx_d = wr_idx_q;
        error_d  = 1'b0;
        count_d  = count_q;
        wr_en    = 1'b0;
        s_ready  = 1'b0;

        // While dropping the tail of an over-long frame, words are swallowed even with both banks full.
        if (!rst) begin
            s_ready = (wstate_q == DROP) || !full_q[wr_sel_q];
        end
        beat = s_valid && s_ready;

        if (beat) begin
            if (wstate_q == DROP) begin
                if (s_last) begin
                    wstate_d = FILL;
                end
            end else begin
                wr_en = 1'b1;
                if (wr_idx_q == LAST_IDX) begin
                    wr_idx_d = '0;
                    if (s_last) begin
                        full_d[wr_sel_q] = 1'b1;
                        wr_sel_d         = !wr_sel_q;
                        count_d          = count_q + 16'd1;
                    end else begin
                        error_d  = 1'b1;
                        wstate_d = DROP;
                    end
                end else if (s_last) begin
                    wr_idx_d = '0;
                    error_d  = 1'b1;
                end else begin
                    wr_idx_d = wr_idx_q + 1'b1;
                end
            end
        end

        // Completion always targets wr_sel and release rd_sel; they cannot be the same bank here.
        if (frame_ack && full_q[rd_sel_q]) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= FILL;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            full_q   <= 2'b00;
            wr_idx_q <= '0;
            error_q  <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            wstate_q <= wstate_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
            wr_idx_q <= wr_idx_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    // Pixel storage carries no reset; full_q alone says whether a bank is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[wr_sel_q][wr_idx_q] <= s_data;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            frame_data[k] = bank_q[rd_sel_q][k];
        end
    end

    assign frame_valid = full_q[rd_sel_q];
    assign frame_error = error_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Self-checking bench for cnn_frame_loader (4x4 frames): table vectors, directed
// corner sequences and a randomized stream checked against a frame-queue model.
module tb_cnn_frame_loader;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] frame_data [N-1:0];
    logic        frame_valid;
    logic        frame_ack;
    logic        frame_error;
    logic [15:0] frame_count;

    cnn_frame_loader #(.input_size(4), .data_width(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_error (frame_error),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: presented/queued frames as a flat word queue (N words per frame),
    // plus the words gathered so far for the frame in flight.
    logic [31:0] pend_words [$];
    logic [31:0] partial [$];
    bit          dropping = 1'b0;
    bit          exp_err  = 1'b0;
    logic [15:0] exp_count = 16'd0;

    typedef struct {
        bit          v;
        bit          l;
        logic [31:0] d;
        bit          a;
        bit          r;
        bit          exp_valid;
        bit          exp_err;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs [6];

    function automatic bit modelReady(input bit r);
        return !r && (dropping || pend_words.size() < 2 * N);
    endfunction

    task automatic modelStep(input bit l, input logic [31:0] d, input bit a, input bit r, input bit acc);
        if (r) begin
            pend_words.delete();
            partial.delete();
            dropping  = 1'b0;
            exp_err   = 1'b0;
            exp_count = 16'd0;
        end else begin
            exp_err = 1'b0;
            if (a && pend_words.size() >= N) begin
                repeat (N) void'(pend_words.pop_front());
            end
            if (acc) begin
                if (dropping) begin
                    if (l) dropping = 1'b0;
                end else begin
                    partial.push_back(d);
                    if (partial.size() == N) begin
                        if (l) begin
                            foreach (partial[i]) pend_words.push_back(partial[i]);
                            exp_count = exp_count + 16'd1;
                        end else begin
                            exp_err  = 1'b1;
                            dropping = 1'b1;
                        end
                        partial.delete();
                    end else if (l) begin
                        exp_err = 1'b1;
                        partial.delete();
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs, check s_ready before the edge, advance the model past the edge.
    task automatic applyStimulus(input bit v, input bit l, input logic [31:0] d, input bit a,
                                 input bit r, output bit acc);
        bit er;
        s_valid   = v;
        s_last    = l;
        s_data    = d;
        frame_ack = a;
        rst       = r;
        #1;
        er = modelReady(r);
        checkOutput("s_ready", 32'(s_ready), 32'(er));
        acc = v && er;
        @(posedge clk);
        modelStep(l, d, a, r, acc);
        #1;
    endtask

    task automatic checkModel();
        bit pv;
        pv = pend_words.size() >= N;
        checkOutput("frame_valid", 32'(frame_valid), 32'(pv));
        checkOutput("frame_error", 32'(frame_error), 32'(exp_err));
        checkOutput("frame_count", 32'(frame_count), 32'(exp_count));
        if (pv) begin
            for (int k = 0; k < N; k++) checkOutput("frame_data", frame_data[k], pend_words[k]);
        end
    endtask

    task automatic step(input bit a, input bit r);
        bit acc;
        applyStimulus(1'b0, 1'b0, 32'd0, a, r, acc);
        checkModel();
    endtask

    task automatic sendWord(input logic [31:0] d, input bit l, input bit a);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 64) begin
            applyStimulus(1'b1, l, d, a, 1'b0, acc);
            checkModel();
            tries++;
        end
        if (!acc) begin
            n_checks++;
            $display("[TB] FAIL sendWord_timeout: word %0h not accepted after %0d cycles", d, tries);
        end
    endtask

    initial begin
        bit acc;
        int sel;
        int len;

        s_valid = 1'b0; s_last = 1'b0; s_data = '0; frame_ack = 1'b0; rst = 1'b1;

        // Reset, idle, ignored ack and a one-word short frame with known outcomes.
        vecs[0] = '{v:1'b0, l:1'b0, d:32'h0,  a:1'b0, r:1'b1, exp_valid:1'b0, exp_err:1'b0, exp_count:16'd0};
        vecs[1] = '{v:1'b1, l:1'b0, d:32'h5,  a:1'b1, r:1'b1, exp_valid:1'b0, exp_err:1'b0, exp_count:16'd0};
        vecs[2] = '{v:1'b0, l:1'b0, d:32'h0,  a:1'b0, r:1'b0, exp_valid:1'b0, exp_err:1'b0, exp_count:16'd0};
        vecs[3] = '{v:1'b0, l:1'b0, d:32'h0,  a:1'b1, r:1'b0, exp_valid:1'b0, exp_err:1'b0, exp_count:16'd0};
        vecs[4] = '{v:1'b1, l:1'b1, d:32'hAA, a:1'b0, r:1'b0, exp_valid:1'b0, exp_err:1'b1, exp_count:16'd0};
        vecs[5] = '{v:1'b0, l:1'b0, d:32'h0,  a:1'b0, r:1'b0, exp_valid:1'b0, exp_err:1'b0, exp_count:16'd0};

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].a, vecs[i].r, acc);
            checkOutput("vec_valid", 32'(frame_valid), 32'(vecs[i].exp_valid));
            checkOutput("vec_error", 32'(frame_error), 32'(vecs[i].exp_err));
            checkOutput("vec_count", 32'(frame_count), 32'(vecs[i].exp_count));
        end

        // Single frame 0..15.
        for (int k = 0; k < N; k++) sendWord(32'(k), k == N - 1, 1'b0);
        checkOutput("single_valid", 32'(frame_valid), 32'd1);
        checkOutput("single_data15", frame_data[15], 32'd15);
        checkOutput("single_data6", frame_data[6], 32'd6);
        checkOutput("single_count", 32'(frame_count), 32'd1);
        checkOutput("single_ready", 32'(s_ready), 32'd1);
        step(1'b1, 1'b0);

        // Ping-pong backpressure.
        for (int k = 0; k < N; k++) sendWord(32'(100 + k), k == N - 1, 1'b0);
        for (int k = 0; k < N; k++) sendWord(32'(200 + k), k == N - 1, 1'b0);
        step(1'b0, 1'b0);
        checkOutput("pp_ready_low", 32'(s_ready), 32'd0);
        checkOutput("pp_first", frame_data[0], 32'd100);
        step(1'b1, 1'b0);
        checkOutput("pp_second", frame_data[3], 32'd203);
        checkOutput("pp_ready_high", 32'(s_ready), 32'd1);
        step(1'b1, 1'b0);
        checkOutput("pp_empty", 32'(frame_valid), 32'd0);
        checkOutput("pp_count", 32'(frame_count), 32'd3);

        // Short frame (last on word 9) followed by a good frame.
        for (int k = 0; k < 10; k++) sendWord(32'(50 + k), k == 9, 1'b0);
        checkOutput("short_err", 32'(frame_error), 32'd1);
        checkOutput("short_novalid", 32'(frame_valid), 32'd0);
        step(1'b0, 1'b0);
        checkOutput("short_err_once", 32'(frame_error), 32'd0);
        for (int k = 0; k < N; k++) sendWord(32'(60 + k), k == N - 1, 1'b0);
        checkOutput("short_next_data", frame_data[0], 32'd60);
        checkOutput("short_next_count", 32'(frame_count), 32'd4);
        step(1'b1, 1'b0);

        // Long frame: 20 words, last only on word 19.
        for (int k = 0; k < 20; k++) begin
            sendWord(32'(700 + k), k == 19, 1'b0);
            if (k == 15) checkOutput("long_err", 32'(frame_error), 32'd1);
        end
        checkOutput("long_novalid", 32'(frame_valid), 32'd0);
        for (int k = 0; k < N; k++) sendWord(32'(300 + k), k == N - 1, 1'b0);
        checkOutput("long_next_idx0", frame_data[0], 32'd300);
        checkOutput("long_next_idx15", frame_data[15], 32'd315);
        step(1'b1, 1'b0);

        // Completion and ack in the same cycle, then an ignored ack.
        for (int k = 0; k < N; k++) sendWord(32'(400 + k), k == N - 1, 1'b0);
        for (int k = 0; k < N; k++) sendWord(32'(500 + k), k == N - 1, k == N - 1);
        checkOutput("conc_valid", 32'(frame_valid), 32'd1);
        checkOutput("conc_data", frame_data[0], 32'd500);
        checkOutput("conc_count", 32'(frame_count), 32'd7);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checkOutput("ign_valid", 32'(frame_valid), 32'd0);
        checkOutput("ign_count", 32'(frame_count), 32'd7);

        // Reset after 7 words, then a fresh frame.
        for (int k = 0; k < 7; k++) sendWord(32'(900 + k), 1'b0, 1'b0);
        step(1'b0, 1'b1);
        checkOutput("rst_count", 32'(frame_count), 32'd0);
        for (int k = 0; k < N - 1; k++) sendWord(32'(800 + k), 1'b0, 1'b0);
        checkOutput("rst_partial_novalid", 32'(frame_valid), 32'd0);
        sendWord(32'(815), 1'b1, 1'b0);
        checkOutput("rst_valid", 32'(frame_valid), 32'd1);
        checkOutput("rst_count1", 32'(frame_count), 32'd1);
        checkOutput("rst_data0", frame_data[0], 32'd800);

        // Randomized stream against the model.
        for (int f = 0; f < 150; f++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) len = $urandom_range(1, 15);
            else if (sel == 1) len = $urandom_range(17, 20);
            else len = N;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) step($urandom_range(0, 2) == 0, 1'b0);
                sendWord($urandom, k == len - 1, $urandom_range(0, 2) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
